// File: rtl/alu_issue_queue.sv
// In-order issue queue feeding the ALU: buffers decoded instructions, drives
// register-file read indices and alu_reg inputs, and holds RAW dependents on a 32-entry scoreboard.
module alu_issue_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [6:0]       enq_opcode,
  input  logic [2:0]       enq_func3,
  input  logic [6:0]       enq_func7,
  input  logic [19:0]      enq_imm,
  input  logic [4:0]       enq_rs1_indx,
  input  logic [4:0]       enq_rs2_indx,
  input  logic [4:0]       enq_rd_indx,
  input  logic [PC_W-1:0]  enq_pc,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd_indx,
  input  logic             flush,
  output logic             i_valid,
  output logic [6:0]       opcode,
  output logic [2:0]       func3,
  output logic [6:0]       func7,
  output logic [19:0]      imm,
  output logic [4:0]       rs1_indx,
  output logic [4:0]       rs2_indx,
  output logic [4:0]       rd_indx,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [6:0]      r_opcode [DEPTH];
  logic [2:0]      r_func3  [DEPTH];
  logic [6:0]      r_func7  [DEPTH];
  logic [19:0]     r_imm    [DEPTH];
  logic [4:0]      r_rs1    [DEPTH];
  logic [4:0]      r_rs2    [DEPTH];
  logic [4:0]      r_rd     [DEPTH];
  logic [PC_W-1:0] r_pc     [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_busy;

  logic        w_nonempty;
  logic        w_enq;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_rs1_blk;
  logic        w_rs2_blk;
  logic [6:0]  w_head_op;
  logic [4:0]  w_head_rs1;
  logic [4:0]  w_head_rs2;
  logic [4:0]  w_head_rd;
  logic [31:0] w_busy_nxt;

  assign w_nonempty = (r_count != '0);
  assign enq_ready  = (r_count != FULL_CNT);
  assign w_enq      = enq_valid && enq_ready && !flush;
  assign count      = r_count;

  assign w_head_op  = r_opcode[r_head];
  assign w_head_rs1 = r_rs1[r_head];
  assign w_head_rs2 = r_rs2[r_head];
  assign w_head_rd  = r_rd[r_head];

  // Source usage is a property of the stored opcode, not of the raw index fields.
  always_comb begin
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b1;
    case (w_head_op)
      7'b0010011, 7'b0011011: w_use_rs2 = 1'b0;
      7'b0110111, 7'b0010111: begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
      end
      default: ;
    endcase
  end

  assign w_rs1_blk = w_use_rs1 && (w_head_rs1 != 5'd0) && r_busy[w_head_rs1];
  assign w_rs2_blk = w_use_rs2 && (w_head_rs2 != 5'd0) && r_busy[w_head_rs2];
  assign i_valid   = w_nonempty && !flush && !w_rs1_blk && !w_rs2_blk;

  assign opcode   = w_nonempty ? w_head_op        : '0;
  assign func3    = w_nonempty ? r_func3[r_head]  : '0;
  assign func7    = w_nonempty ? r_func7[r_head]  : '0;
  assign imm      = w_nonempty ? r_imm[r_head]    : '0;
  assign rs1_indx = w_nonempty ? w_head_rs1       : '0;
  assign rs2_indx = w_nonempty ? w_head_rs2       : '0;
  assign rd_indx  = w_nonempty ? w_head_rd        : '0;
  assign pc       = w_nonempty ? r_pc[r_head]     : '0;

  // NOTE: blocking assignments in combinational logic execute in order, so the
  // later set overrides an earlier clear of the same index.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid) w_busy_nxt[wb_rd_indx] = 1'b0;
    if (i_valid && (w_head_rd != 5'd0)) w_busy_nxt[w_head_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // NOTE: payload storage has no reset; outputs are masked while empty and
  // an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_opcode[r_tail] <= enq_opcode;
      r_func3[r_tail]  <= enq_func3;
      r_func7[r_tail]  <= enq_func7;
      r_imm[r_tail]    <= enq_imm;
      r_rs1[r_tail]    <= enq_rs1_indx;
      r_rs2[r_tail]    <= enq_rs2_indx;
      r_rd[r_tail]     <= enq_rd_indx;
      r_pc[r_tail]     <= enq_pc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
    end else begin
      // Scoreboard survives flush: in-flight ALU ops still write back.
      r_busy <= w_busy_nxt;
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_enq)   r_tail <= r_tail + PTR_W'(1);
        if (i_valid) r_head <= r_head + PTR_W'(1);
        case ({w_enq, i_valid})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model with an emulated ALU writeback path.
module tb_alu_issue_queue;

  localparam int DEPTH = 8;
  localparam int PC_W  = 64;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct {
    logic [6:0]      op;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [19:0]     imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [PC_W-1:0] pc;
  } ent_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enq_valid;
  logic             enq_ready;
  logic [6:0]       enq_opcode;
  logic [2:0]       enq_func3;
  logic [6:0]       enq_func7;
  logic [19:0]      enq_imm;
  logic [4:0]       enq_rs1_indx;
  logic [4:0]       enq_rs2_indx;
  logic [4:0]       enq_rd_indx;
  logic [PC_W-1:0]  enq_pc;
  logic             wb_valid;
  logic [4:0]       wb_rd_indx;
  logic             flush;
  logic             i_valid;
  logic [6:0]       opcode;
  logic [2:0]       func3;
  logic [6:0]       func7;
  logic [19:0]      imm;
  logic [4:0]       rs1_indx;
  logic [4:0]       rs2_indx;
  logic [4:0]       rd_indx;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] count;

  alu_issue_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_opcode(enq_opcode), .enq_func3(enq_func3), .enq_func7(enq_func7),
    .enq_imm(enq_imm), .enq_rs1_indx(enq_rs1_indx), .enq_rs2_indx(enq_rs2_indx),
    .enq_rd_indx(enq_rd_indx), .enq_pc(enq_pc),
    .wb_valid(wb_valid), .wb_rd_indx(wb_rd_indx), .flush(flush),
    .i_valid(i_valid), .opcode(opcode), .func3(func3), .func7(func7), .imm(imm),
    .rs1_indx(rs1_indx), .rs2_indx(rs2_indx), .rd_indx(rd_indx), .pc(pc), .count(count)
  );

  always #5 clk = ~clk;

  // Reference state: program-order queue, scoreboard bits, and the ALU's pending writebacks.
  ent_t        q[$];
  logic [31:0] busy;
  logic [4:0]  pend[$];
  logic        wb_hold;
  int          n_checks;
  int          n_pass;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_RW   = 7'b0111011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_IW   = 7'b0011011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic ent_t mk(input logic [6:0] op, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd);
    ent_t e;
    e.op  = op;
    e.rs1 = rs1;
    e.rs2 = rs2;
    e.rd  = rd;
    e.f3  = 3'($urandom);
    e.f7  = 7'($urandom);
    e.imm = 20'($urandom);
    e.pc  = {32'($urandom), 32'($urandom)};
    return e;
  endfunction

  function automatic logic ready_src(input logic [6:0] op, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [31:0] bz);
    bit need1, need2;
    need1 = !(op == OP_LUI || op == OP_AUI);
    need2 = need1 && !(op == OP_I || op == OP_IW);
    return !(need1 && rs1 != 0 && bz[rs1]) && !(need2 && rs2 != 0 && bz[rs2]);
  endfunction

  task automatic step(input logic ev, input ent_t e, input logic fl);
    ent_t         h;
    logic         exp_valid;
    logic [127:0] exp_fields;
    bit           was_full;
    @(negedge clk);
    enq_valid    = ev;
    enq_opcode   = e.op;
    enq_func3    = e.f3;
    enq_func7    = e.f7;
    enq_imm      = e.imm;
    enq_rs1_indx = e.rs1;
    enq_rs2_indx = e.rs2;
    enq_rd_indx  = e.rd;
    enq_pc       = e.pc;
    flush        = fl;
    if (!wb_hold && pend.size() > 0) begin
      wb_valid   = 1'b1;
      wb_rd_indx = pend.pop_front();
    end else begin
      wb_valid   = 1'b0;
      wb_rd_indx = 5'($urandom);
    end
    #1;
    exp_valid  = 1'b0;
    exp_fields = '0;
    if (q.size() != 0) begin
      h = q[0];
      exp_fields = {h.op, h.f3, h.f7, h.imm, h.rs1, h.rs2, h.rd, h.pc};
      exp_valid  = !fl && ready_src(h.op, h.rs1, h.rs2, busy);
    end
    check("i_valid", i_valid, exp_valid);
    check("count", count, q.size());
    check("enq_ready", enq_ready, q.size() != DEPTH);
    check("head_fields", {opcode, func3, func7, imm, rs1_indx, rs2_indx, rd_indx, pc}, exp_fields);
    @(posedge clk);
    if (wb_valid) busy[wb_rd_indx] = 1'b0;
    if (exp_valid) begin
      if (h.rd != 0) busy[h.rd] = 1'b1;
      pend.push_back(h.rd);
    end
    if (fl) q.delete();
    else begin
      was_full = (q.size() == DEPTH);
      if (exp_valid) void'(q.pop_front());
      if (ev && !was_full) q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, mk(OP_I, 0, 0, 0), 1'b0);
  endtask

  initial begin
    logic [6:0] ops [7];
    ent_t e;
    ops = '{OP_R, OP_RW, OP_I, OP_IW, OP_LUI, OP_AUI, 7'b1100011};
    n_checks = 0; n_pass = 0;
    busy = '0; wb_hold = 1'b0;
    reset_n = 1'b0; enq_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_rd_indx = '0;
    enq_opcode = '0; enq_func3 = '0; enq_func7 = '0; enq_imm = '0;
    enq_rs1_indx = '0; enq_rs2_indx = '0; enq_rd_indx = '0; enq_pc = '0;
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_i_valid", i_valid, 0);
    check("rst_enq_ready", enq_ready, 1);
    check("rst_rd_indx", rd_indx, 0);
    reset_n = 1'b1;

    // Independent addi stream.
    step(1'b1, mk(OP_I, 0, 0, 1), 1'b0);
    step(1'b1, mk(OP_I, 0, 0, 2), 1'b0);
    step(1'b1, mk(OP_I, 0, 0, 3), 1'b0);
    idle(4);

    // RAW: add x6,x5,x5 waits one bubble for addi x5.
    step(1'b1, mk(OP_I, 0, 0, 5), 1'b0);
    step(1'b1, mk(OP_R, 5, 5, 6), 1'b0);
    idle(4);

    // LUI with a stray rs1 of a busy register.
    wb_hold = 1'b1;
    step(1'b1, mk(OP_I, 0, 0, 5), 1'b0);
    idle(1);
    step(1'b1, mk(OP_LUI, 5, 5, 7), 1'b0);
    idle(2);
    wb_hold = 1'b0;
    idle(3);

    // Full queue behind busy x9, then release.
    wb_hold = 1'b1;
    step(1'b1, mk(OP_I, 0, 0, 9), 1'b0);
    idle(1);
    for (int i = 0; i < 9; i++) step(1'b1, mk(OP_I, 9, 0, 5'(10 + i)), 1'b0);
    idle(1);
    wb_hold = 1'b0;
    idle(14);

    // Flush with concurrent enqueue; scoreboard must survive.
    wb_hold = 1'b1;
    step(1'b1, mk(OP_I, 0, 0, 3), 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b1, mk(OP_R, 3, 3, 5'(20 + i)), 1'b0);
    step(1'b1, mk(OP_I, 0, 0, 25), 1'b1);
    step(1'b1, mk(OP_R, 3, 3, 4), 1'b0);
    idle(2);
    wb_hold = 1'b0;
    idle(4);

    // rd = x0 never marks x0 busy.
    step(1'b1, mk(OP_R, 1, 2, 0), 1'b0);
    step(1'b1, mk(OP_R, 0, 0, 8), 1'b0);
    idle(3);

    // Asynchronous reset mid-run with count = 4 and x3 busy.
    wb_hold = 1'b1;
    step(1'b1, mk(OP_I, 0, 0, 3), 1'b0);
    idle(1);
    for (int i = 0; i < 4; i++) step(1'b1, mk(OP_R, 3, 3, 5'(11 + i)), 1'b0);
    @(negedge clk);
    enq_valid = 1'b0; wb_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_i_valid", i_valid, 0);
    check("midrst_enq_ready", enq_ready, 1);
    q.delete(); pend.delete(); busy = '0; wb_hold = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    step(1'b1, mk(OP_R, 3, 3, 4), 1'b0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      wb_hold = ($urandom_range(0, 3) == 0);
      e = mk(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step($urandom_range(0, 3) != 0, e, $urandom_range(0, 39) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
